multdiv_unit: RTL and testbench

Iterative signed 32-bit multiply/divide unit in the execute stage, beside the ALU. Sequences a one-bit-per-cycle multiply and divide over a fixed 32 iterations. Drives the stall/ready handshake that freezes the pipeline while an operation runs. Its `data_exception` and `exc_is_div` outputs feed the overflow/rstatus logic, which writes rstatus = 4 (mult) or 5 (div) on an exception.

---
 rtl/multdiv_unit_if.sv | 26 ++
 rtl/multdiv_unit.sv | 143 ++++++++++++++
 tb/tb_multdiv_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/multdiv_unit_if.sv
// Bus between the execute stage and the iterative multiply/divide unit.
// It carries the start requests, the operands, the results and the stall signals.
interface multdiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             exc_is_div;
  logic             data_resultRDY;
  logic             busy;
  logic [1:0]       dbg_state;

  modport master (
    output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, exc_is_div, data_resultRDY, busy, dbg_state
  );

  modport slave (
    input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, exc_is_div, data_resultRDY, busy, dbg_state
  );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiply (shift-add) and divide (restoring) unit, one bit per cycle.
// It runs a fixed WIDTH iterations and stalls the pipeline through busy.
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clock,
  input  logic          reset,
  multdiv_unit_if.slave bus
);
  // Handshake: a request (ctrl_MULT or ctrl_DIV) is accepted at an edge whenever
  // busy is 0. busy stays 1 for WIDTH cycles. data_resultRDY then pulses for one
  // cycle, and a new request may be accepted in that same cycle.
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic             accept, last_step;

  logic             op_div, neg, div_zero, div_ovf;
  logic [WIDTH-1:0] mag_m, acc, lo;
  logic [WIDTH-1:0] acc_nxt, lo_nxt;
  logic [WIDTH:0]   sum, shifted, diff;
  logic [2*WIDTH-1:0] prod, sprod;
  logic [WIDTH-1:0] sq;
  logic             mul_exc;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic             ovf_pair;

  logic [WIDTH-1:0] result_q;
  logic             exc_q, is_div_q;

  assign accept    = (state != RUN) && (bus.ctrl_MULT || bus.ctrl_DIV);
  assign last_step = (state == RUN) && (count == LAST);

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (count == LAST) state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.busy           = (state == RUN);
    bus.data_resultRDY = (state == DONE);
    bus.dbg_state      = state;
  end

  // Operands are reduced to magnitudes at accept; the sign is applied after the last step.
  assign a_neg    = bus.data_operandA[WIDTH-1];
  assign b_neg    = bus.data_operandB[WIDTH-1];
  assign mag_a    = a_neg ? -bus.data_operandA : bus.data_operandA;
  assign mag_b    = b_neg ? -bus.data_operandB : bus.data_operandB;
  assign ovf_pair = (bus.data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                    (bus.data_operandB == {WIDTH{1'b1}});

  always_comb begin
    sum     = {1'b0, acc} + {1'b0, (lo[0] ? mag_m : {WIDTH{1'b0}})};
    shifted = {acc, lo[WIDTH-1]};
    diff    = shifted - {1'b0, mag_m};
    acc_nxt = acc;
    lo_nxt  = lo;
    if (op_div) begin
      if (!diff[WIDTH]) begin
        acc_nxt = diff[WIDTH-1:0];
        lo_nxt  = {lo[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = shifted[WIDTH-1:0];
        lo_nxt  = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_nxt = sum[WIDTH:1];
      lo_nxt  = {sum[0], lo[WIDTH-1:1]};
    end
    prod    = {acc_nxt, lo_nxt};
    sprod   = neg ? -prod : prod;
    sq      = neg ? -lo_nxt : lo_nxt;
    // The product fits in WIDTH signed bits only if its top WIDTH+1 bits are all equal.
    mul_exc = ~((&sprod[2*WIDTH-1:WIDTH-1]) | ~(|sprod[2*WIDTH-1:WIDTH-1]));
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count    <= '0;
      op_div   <= 1'b0;
      neg      <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
      mag_m    <= '0;
      acc      <= '0;
      lo       <= '0;
    end else if (accept) begin
      count    <= '0;
      op_div   <= !bus.ctrl_MULT;
      neg      <= a_neg ^ b_neg;
      div_zero <= (bus.data_operandB == '0);
      div_ovf  <= ovf_pair;
      mag_m    <= bus.ctrl_MULT ? mag_a : mag_b;
      lo       <= bus.ctrl_MULT ? mag_b : mag_a;
      acc      <= '0;
    end else if (state == RUN) begin
      count    <= count + 1'b1;
      acc      <= acc_nxt;
      lo       <= lo_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      result_q <= '0;
      exc_q    <= 1'b0;
      is_div_q <= 1'b0;
    end else if (last_step) begin
      if (op_div) begin
        is_div_q <= 1'b1;
        exc_q    <= div_zero | div_ovf;
        if (div_zero)     result_q <= '0;
        else if (div_ovf) result_q <= {1'b1, {(WIDTH-1){1'b0}}};
        else              result_q <= sq;
      end else begin
        is_div_q <= 1'b0;
        exc_q    <= mul_exc;
        result_q <= sprod[WIDTH-1:0];
      end
    end
  end

  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.exc_is_div     = is_div_q;
endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: a scoreboard of expected {exception, is_div, result}
// is filled at each request and drained on each completion pulse.
module tb_multdiv_unit;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  multdiv_unit_if #(.WIDTH(32)) bus ();
  multdiv_unit #(.WIDTH(32)) dut (.clock(clock), .reset(reset), .bus(bus));

  int passed = 0;
  int failed = 0;
  int total  = 0;
  logic [33:0] exp_q[$];
  logic [33:0] last_exp = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [33:0] model(input bit m, input logic [31:0] a, input logic [31:0] b);
    longint p;
    longint lim;
    int q;
    logic [31:0] qv;
    logic [31:0] pl;
    lim = 64'sd2147483647;
    if (m) begin
      p  = longint'($signed(a)) * longint'($signed(b));
      pl = p[31:0];
      return {(p > lim) || (p < -lim - 1), 1'b0, pl};
    end
    if (b == 32'h0) return {1'b1, 1'b1, 32'h0};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b1, 1'b1, 32'h8000_0000};
    q  = $signed(a) / $signed(b);
    qv = q;
    return {1'b0, 1'b1, qv};
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_result"}, {32'h0, bus.data_result}, 64'h0);
    check({tag, "_exc"},    {63'h0, bus.data_exception}, 64'h0);
    check({tag, "_isdiv"},  {63'h0, bus.exc_is_div}, 64'h0);
    check({tag, "_rdy"},    {63'h0, bus.data_resultRDY}, 64'h0);
    check({tag, "_busy"},   {63'h0, bus.busy}, 64'h0);
    check({tag, "_state"},  {62'h0, bus.dbg_state}, 64'h0);
  endtask

  // Advances n cycles; each cycle must show no pulse and the last result held.
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
      @(negedge clock);
      check("idle_rdy", {63'h0, bus.data_resultRDY}, 64'h0);
      check("idle_hold", {32'h0, bus.data_result}, {32'h0, last_exp[31:0]});
    end
  endtask

  // mode 0: plain op; mode 1: divide request pulsed in cycle 10; mode 2: reset in cycle 12.
  task automatic do_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b, input int mode);
    logic [33:0] e;
    bus.ctrl_MULT     = m;
    bus.ctrl_DIV      = d;
    bus.data_operandA = a;
    bus.data_operandB = b;
    exp_q.push_back(model(m, a, b));
    @(posedge clock); #1;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = $urandom;
    bus.data_operandB = $urandom;
    for (int k = 1; k <= 33; k++) begin
      @(negedge clock);
      if (k < 33) begin
        check("run_busy", {63'h0, bus.busy}, 64'h1);
        check("run_rdy",  {63'h0, bus.data_resultRDY}, 64'h0);
        if (k == 16) check("run_hold", {32'h0, bus.data_result}, {32'h0, last_exp[31:0]});
        if (mode == 1 && k == 10) begin
          bus.ctrl_DIV      = 1'b1;
          bus.data_operandA = $urandom;
          bus.data_operandB = $urandom_range(1, 100);
        end
        if (mode == 1 && k == 11) bus.ctrl_DIV = 1'b0;
        if (mode == 2 && k == 12) begin
          reset = 1'b0;
          @(posedge clock); #1;
          reset = 1'b1;
          @(negedge clock);
          check_zero("mid_reset");
          void'(exp_q.pop_back());
          last_exp = '0;
          for (int j = 0; j < 40; j++) begin
            @(posedge clock); #1;
            @(negedge clock);
            check("abort_no_rdy", {63'h0, bus.data_resultRDY}, 64'h0);
          end
          return;
        end
        @(posedge clock); #1;
      end else begin
        check("done_rdy",  {63'h0, bus.data_resultRDY}, 64'h1);
        check("done_busy", {63'h0, bus.busy}, 64'h0);
        if (exp_q.size() == 0) begin
          check("scoreboard_empty", 64'h1, 64'h0);
        end else begin
          e = exp_q.pop_front();
          check("result", {32'h0, bus.data_result}, {32'h0, e[31:0]});
          check("exception", {63'h0, bus.data_exception}, {63'h0, e[33]});
          check("exc_is_div", {63'h0, bus.exc_is_div}, {63'h0, e[32]});
          last_exp = e;
        end
      end
    end
  endtask

  initial begin
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check_zero("reset");
    reset = 1'b1;

    do_op(1'b1, 1'b0, 32'd7, 32'd6, 0);
    idle(2);
    do_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 0);
    idle(1);
    do_op(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5, 0);
    idle(1);
    do_op(1'b1, 1'b0, 32'h8000_0000, 32'd1, 0);
    idle(1);
    do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
    idle(1);
    do_op(1'b0, 1'b1, 32'd5, 32'd0, 0);
    idle(1);
    do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    idle(1);
    do_op(1'b1, 1'b1, 32'd9, 32'd3, 1);
    idle(1);
    do_op(1'b1, 1'b0, $urandom, $urandom, 2);
    idle(1);
    do_op(1'b1, 1'b0, 32'd123, 32'hFFFF_FFD3, 0);
    do_op(1'b0, 1'b1, 32'd100, 32'd7, 0);
    check("b2b_second", {32'h0, bus.data_result}, 64'd14);
    idle(5);
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 1) == 1) do_op(1'b1, 1'b0, $urandom, $urandom_range(0, 65535), 0);
      else                           do_op(1'b0, 1'b1, $urandom, $urandom, 0);
      idle(1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
